// File: rtl/decoder_n_bit_seq_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared types and constants for the sequenced one-hot decoder.
//   dec_state_e     : FSM state encoding (IDLE / HOLD / SWEEP)
//   DEC_MODE_*      : command mode values carried on in_mode
//   DEC_MAX_W/N     : widest supported index / one-hot word
//   onehot_of()     : reference helper returning 1 << idx for an index width w
// -----------------------------------------------------------------------------
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SWEEP = 2'd2
    } dec_state_e;

    localparam logic DEC_MODE_SINGLE = 1'b0;
    localparam logic DEC_MODE_SWEEP  = 1'b1;

    localparam int DEC_MAX_W = 8;
    localparam int DEC_MAX_N = 1 << DEC_MAX_W;

    // Returns 1 << idx within a DEC_MAX_N-bit word; indices outside 2^w
    // give an all-zero word rather than a wrapped bit.
    function automatic logic [DEC_MAX_N-1:0] onehot_of(
        input logic [DEC_MAX_W-1:0] idx,
        input int                   w
    );
        logic [DEC_MAX_N-1:0] v;
        v = '0;
        if (int'(idx) < (1 << w)) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/decoder_n_bit_seq_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec_comb
// Pure combinational W -> 2^W one-hot decoder with selectable port polarity.
//   i_idx  : binary index to decode
//   i_en   : 0 forces the "nothing selected" word (all 0, or all 1 one-cold)
//   o_word : 1 << i_idx, inverted when ACTIVE_LOW = 1
// -----------------------------------------------------------------------------
module onehot_dec_comb
    import decoder_pkg::*;
#(
    parameter int W          = 4,
    parameter bit ACTIVE_LOW = 1'b0
)
(
    input  logic [W-1:0]        i_idx,
    input  logic                i_en,
    output logic [(1<<W)-1:0]   o_word
);

    localparam int N = 1 << W;
    localparam logic [N-1:0] LSB_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] w_hot;

    always_comb begin
        w_hot = '0;
        if (i_en) begin
            w_hot = LSB_ONE << i_idx;
        end
    end

    // Polarity is applied only at the boundary so the core logic is identical
    // for one-hot and one-cold builds.
    assign o_word = ACTIVE_LOW ? ~w_hot : w_hot;

endmodule

// File: rtl/decoder_n_bit_seq.sv
// -----------------------------------------------------------------------------
// decoder_n_bit_seq
// Registered W -> 2^W one-hot decoder behind a valid/ready handshake, with a
// sweep mode that walks the one-hot bit from 0 up to the commanded index, one
// beat per accepted output.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid/in_ready, in_sel, in_mode : command channel (mode 0 decode, 1 sweep)
//   out_valid/out_ready                : beat channel
//   out_onehot   : decoded word (one-cold when ACTIVE_LOW = 1)
//   out_idx      : binary index of the asserted bit
//   out_last     : final beat of the current command
//
// state | meaning
// IDLE  | no beat held
// HOLD  | final (last) beat of a command is presented
// SWEEP | non-final sweep beat is presented
// -----------------------------------------------------------------------------
module decoder_n_bit_seq
    import decoder_pkg::*;
#(
    parameter int W          = 4,
    parameter bit ACTIVE_LOW = 1'b0
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_sel,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [(1<<W)-1:0]   out_onehot,
    output logic [W-1:0]        out_idx,
    output logic                out_last
);

    dec_state_e   r_state;
    dec_state_e   w_state_nxt;
    logic [W-1:0] r_idx;
    logic [W-1:0] w_idx_nxt;
    logic [W-1:0] r_target;
    logic [W-1:0] w_target_nxt;
    logic         r_last;
    logic         w_last_nxt;
    logic         r_loaded;
    logic         w_loaded_nxt;

    logic         w_in_ready;
    logic         w_accept;
    logic         w_adv;
    logic [W-1:0] w_idx_inc;
    logic         w_step_last;

    assign out_valid = (r_state != IDLE);

    // Output register may load when nothing is held or the held beat leaves.
    assign w_adv = !out_valid || out_ready;

    // A new command can only be taken when no sweep is in flight; in HOLD it
    // replaces the final beat on the same edge that beat is consumed.
    always_comb begin
        w_in_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE:    w_in_ready = 1'b1;
                HOLD:    w_in_ready = out_ready;
                SWEEP:   w_in_ready = 1'b0;
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    assign in_ready = w_in_ready;
    assign w_accept = in_valid && w_in_ready;

    // In SWEEP r_idx is always below r_target, so the increment never wraps.
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_step_last = (w_idx_inc == r_target);

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_target_nxt = r_target;
        w_last_nxt   = r_last;
        w_loaded_nxt = r_loaded;

        case (r_state)
            IDLE, HOLD: begin
                if (w_accept) begin
                    w_loaded_nxt = 1'b1;
                    if (in_mode == DEC_MODE_SWEEP) begin
                        w_idx_nxt    = '0;
                        w_target_nxt = in_sel;
                        w_last_nxt   = (in_sel == '0);
                        if (in_sel == '0) begin
                            w_state_nxt = HOLD;
                        end else begin
                            w_state_nxt = SWEEP;
                        end
                    end else begin
                        w_idx_nxt   = in_sel;
                        w_last_nxt  = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if ((r_state == HOLD) && w_adv) begin
                    // Beat consumed with nothing behind it; the word and index
                    // stay visible, only out_valid drops.
                    w_state_nxt = IDLE;
                end
            end

            SWEEP: begin
                if (w_adv) begin
                    w_idx_nxt  = w_idx_inc;
                    w_last_nxt = w_step_last;
                    if (w_step_last) begin
                        w_state_nxt = HOLD;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_target <= '0;
            r_last   <= 1'b0;
            r_loaded <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_target <= w_target_nxt;
            r_last   <= w_last_nxt;
            r_loaded <= w_loaded_nxt;
        end
    end

    assign out_idx  = r_idx;
    assign out_last = r_last;

    // r_loaded keeps the port at its reset word until the first command lands,
    // since index 0 would otherwise decode to bit 0 straight out of reset.
    onehot_dec_comb #(
        .W          (W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .i_idx  (r_idx),
        .i_en   (r_loaded),
        .o_word (out_onehot)
    );

endmodule

// File: tb/tb_decoder_n_bit_seq.sv
module tb_decoder_n_bit_seq;

    localparam int ND = 4;

    typedef struct {
        int idx;
        bit last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_mode;
    logic       out_ready;
    logic [7:0] in_sel;

    always #5 clk = ~clk;

    // Instance 0: W=4 one-hot, 1: W=4 one-cold, 2: W=1, 3: W=8
    logic          rdy0, vld0, lst0;
    logic [15:0]   hot0;
    logic [3:0]    idx0;
    logic          rdy1, vld1, lst1;
    logic [15:0]   hot1;
    logic [3:0]    idx1;
    logic          rdy2, vld2, lst2;
    logic [1:0]    hot2;
    logic [0:0]    idx2;
    logic          rdy3, vld3, lst3;
    logic [255:0]  hot3;
    logic [7:0]    idx3;

    decoder_n_bit_seq #(.W(4), .ACTIVE_LOW(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_sel(in_sel[3:0]),
        .in_mode(in_mode), .out_valid(vld0), .out_ready(out_ready), .out_onehot(hot0),
        .out_idx(idx0), .out_last(lst0));

    decoder_n_bit_seq #(.W(4), .ACTIVE_LOW(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_sel(in_sel[3:0]),
        .in_mode(in_mode), .out_valid(vld1), .out_ready(out_ready), .out_onehot(hot1),
        .out_idx(idx1), .out_last(lst1));

    decoder_n_bit_seq #(.W(1), .ACTIVE_LOW(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_sel(in_sel[0:0]),
        .in_mode(in_mode), .out_valid(vld2), .out_ready(out_ready), .out_onehot(hot2),
        .out_idx(idx2), .out_last(lst2));

    decoder_n_bit_seq #(.W(8), .ACTIVE_LOW(1'b0)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in_sel(in_sel[7:0]),
        .in_mode(in_mode), .out_valid(vld3), .out_ready(out_ready), .out_onehot(hot3),
        .out_idx(idx3), .out_last(lst3));

    logic         o_vld [ND];
    logic         o_rdy [ND];
    logic         o_lst [ND];
    logic [255:0] o_hot [ND];
    logic [7:0]   o_idx [ND];

    assign o_vld[0] = vld0;  assign o_rdy[0] = rdy0;  assign o_lst[0] = lst0;
    assign o_vld[1] = vld1;  assign o_rdy[1] = rdy1;  assign o_lst[1] = lst1;
    assign o_vld[2] = vld2;  assign o_rdy[2] = rdy2;  assign o_lst[2] = lst2;
    assign o_vld[3] = vld3;  assign o_rdy[3] = rdy3;  assign o_lst[3] = lst3;
    assign o_hot[0] = 256'(hot0);  assign o_idx[0] = 8'(idx0);
    assign o_hot[1] = 256'(hot1);  assign o_idx[1] = 8'(idx1);
    assign o_hot[2] = 256'(hot2);  assign o_idx[2] = 8'(idx2);
    assign o_hot[3] = hot3;        assign o_idx[3] = idx3;

    int dw  [ND] = '{4, 4, 1, 8};
    bit dal [ND] = '{1'b0, 1'b1, 1'b0, 1'b0};

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] exp_hot(input int w, input bit al, input bit loaded, input int idx);
        logic [255:0] v;
        logic [255:0] m;
        v = '0;
        m = '0;
        for (int i = 0; i < (1 << w); i++) m[i] = 1'b1;
        if (loaded) v[idx] = 1'b1;
        if (al) v = ~v & m;
        return v;
    endfunction

    // Reference model: each accepted command expands into its list of beats;
    // the front of the list is what the port must be presenting.
    beat_t q [ND][$];
    bit    loaded [ND];
    int    h_idx  [ND];
    bit    h_last [ND];

    always @(negedge clk) begin
        bit ev;
        bit elast;
        bit erdy;
        int eidx;
        int sel;
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                ev = (q[d].size() != 0);
                if (ev) begin
                    eidx  = q[d][0].idx;
                    elast = q[d][0].last;
                end else begin
                    eidx  = h_idx[d];
                    elast = h_last[d];
                end
                erdy = !rst && (!ev || (elast && out_ready));

                chk($sformatf("d%0d_vld", d), 256'(o_vld[d]), 256'(ev));
                chk($sformatf("d%0d_rdy", d), 256'(o_rdy[d]), 256'(erdy));
                chk($sformatf("d%0d_hot", d), o_hot[d], exp_hot(dw[d], dal[d], loaded[d], eidx));
                chk($sformatf("d%0d_idx", d), 256'(o_idx[d]), 256'(eidx));
                chk($sformatf("d%0d_last", d), 256'(o_lst[d]), 256'(elast));

                if (rst) begin
                    q[d].delete();
                    loaded[d] = 1'b0;
                    h_idx[d]  = 0;
                    h_last[d] = 1'b0;
                end else begin
                    if (ev && out_ready) begin
                        h_idx[d]  = eidx;
                        h_last[d] = elast;
                        void'(q[d].pop_front());
                    end
                    if (in_valid && erdy) begin
                        sel = int'(in_sel) & ((1 << dw[d]) - 1);
                        loaded[d] = 1'b1;
                        if (in_mode == 1'b0) begin
                            q[d].push_back('{idx: sel, last: 1'b1});
                        end else begin
                            for (int k = 0; k <= sel; k++) begin
                                q[d].push_back('{idx: k, last: (k == sel)});
                            end
                        end
                    end
                end
            end
        end
    end

    logic [15:0] sw_exp [5] = '{16'h0002, 16'h0002, 16'h0004, 16'h0008, 16'h0008};
    bit          sw_rdy [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [15:0] e16;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_sel    = 8'h00;
        out_ready = 1'b0;

        step();
        chk_en = 1'b1;
        chk("rst_vld0", 256'(vld0), 256'(0));
        chk("rst_hot0", 256'(hot0), 256'(0));
        chk("rst_hot1", 256'(hot1), 256'(16'hFFFF));
        chk("rst_idx0", 256'(idx0), 256'(0));
        chk("rst_last0", 256'(lst0), 256'(0));
        chk("rst_rdy0", 256'(rdy0), 256'(0));
        step();
        rst = 1'b0;
        #1;
        chk("idle_rdy0", 256'(rdy0), 256'(1));

        // Single decode of 0xA
        in_valid = 1'b1; in_mode = 1'b0; in_sel = 8'h0A; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("dec_vld", 256'(vld0), 256'(1));
        chk("dec_hot", 256'(hot0), 256'(16'h0400));
        chk("dec_idx", 256'(idx0), 256'(10));
        chk("dec_last", 256'(lst0), 256'(1));
        step();
        chk("dec_drop", 256'(vld0), 256'(0));

        // Back-to-back decodes
        in_valid = 1'b1; in_sel = 8'h03;
        step();
        chk("b2b_3", 256'(hot0), 256'(16'h0008));
        in_sel = 8'h07;
        step();
        chk("b2b_7", 256'(hot0), 256'(16'h0080));
        in_sel = 8'h0F;
        step();
        chk("b2b_15", 256'(hot0), 256'(16'h8000));
        in_valid = 1'b0;
        step();
        chk("b2b_end", 256'(vld0), 256'(0));

        // Sweep to 3 with a stalling consumer
        in_valid = 1'b1; in_mode = 1'b1; in_sel = 8'h03; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("sw_b0", 256'(hot0), 256'(16'h0001));
        chk("sw_b0_last", 256'(lst0), 256'(0));
        for (int i = 0; i < 6; i++) begin
            out_ready = sw_rdy[i];
            step();
            if (i < 5) chk($sformatf("sw_s%0d", i), 256'(hot0), 256'(sw_exp[i]));
            else       chk("sw_done", 256'(vld0), 256'(0));
        end

        // Full one-cold sweep to 15
        in_valid = 1'b1; in_mode = 1'b1; in_sel = 8'h0F; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            e16 = ~(16'h0001 << k);
            chk($sformatf("full_hot%0d", k), 256'(hot1), 256'(e16));
            chk($sformatf("full_idx%0d", k), 256'(idx1), 256'(k));
            step();
        end
        chk("full_end", 256'(vld1), 256'(0));

        // Reset in the middle of a sweep to 9
        in_valid = 1'b1; in_mode = 1'b1; in_sel = 8'h09; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        chk("mid_idx", 256'(idx0), 256'(5));
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_vld", 256'(vld0), 256'(0));
        chk("mid_hot", 256'(hot0), 256'(0));
        chk("mid_rdy", 256'(rdy0), 256'(1));
        in_valid = 1'b1; in_mode = 1'b0; in_sel = 8'h02;
        step();
        in_valid = 1'b0;
        chk("post_rst", 256'(hot0), 256'(16'h0004));
        step();

        // Random traffic across all widths
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 599) == 0);
            in_valid  = $urandom_range(0, 1);
            in_mode   = $urandom_range(0, 1);
            in_sel    = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (300) step();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("d%0d_drain", d), 256'(q[d].size()), 256'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
